pipelined_control_unit: RTL
===========================

Name: pipelined_control_unit

Overview:
Parametrised successor to the single-cycle ARM-subset decoder. Decodes the ID-stage instruction into an ALU opcode plus a control bundle, then registers it through ID/EX, EX/MEM and MEM/WB stages. Adds condition-code evaluation in EX, bubble insertion on stall or flush, and load-use hazard detection. Sits between instruction fetch and the datapath stage registers.

Parameters:
ALU_OP_W, 4, ALU opcode width
NUM_REGS, 16, register-file size; REG_IDX_W = $clog2(NUM_REGS)
NOP_ALU_OP, 4'b1110, opcode emitted for bubbles and undecoded instructions

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
instr_id  in  32  instruction in ID
instr_valid  in  1  instr_id is valid
stall  in  1  external stall; bubble into ID/EX
flush  in  1  branch redirect; bubble into ID/EX
flags_ex  in  4  NZCV for the EX-stage instruction
ex_alu_op  out  ALU_OP_W  EX opcode
ex_ctrl  out  CTRL_W  EX bundle (condition-gated)
ex_rd  out  REG_IDX_W  EX destination register
mem_ctrl  out  CTRL_W  MEM bundle
wb_ctrl  out  CTRL_W  WB bundle
wb_rd  out  REG_IDX_W  WB destination register
cond_pass  out  1  EX condition true
branch_taken  out  1  EX is B/BL and cond_pass
hazard_stall  out  1  load-use hazard; upstream holds IF/ID

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: all stage registers hold a bubble. All ctrl outputs are 0, alu_op is NOP_ALU_OP, rd is 0, and cond_pass, branch_taken and hazard_stall are 0.
- CTRL bundle bits: am, s_en, load, rf_en, size (1 = byte), rw (1 = write), mem_en, bl, b.
- Instruction classes:
  - DP: [27:26]=00 and not ([25]=0 & [7]=1 & [4]=1).
  - LS: [27:26]=01 and not ([25]=1 & [4]=1).
  - BR: [27:25]=101.
  - Anything else is a bubble.
- DP opcode map, [24:21] to alu_op:
  - AND→0110, EOR→1000, SUB→0010, RSB→0100, ADD→0000, ADC→0001, SBC→0011, RSC→0101
  - TST→0110, TEQ→1000, CMP→0010, CMN→0000
  - ORR→0111, MOV→1010, BIC→1100, MVN→1011
- DP controls:
  - am = [25]; s_en = [20]; rf_en = 1.
  - TST/TEQ/CMP/CMN: rf_en = 0 and s_en forced to 1.
  - rd = [15:12].
- LS controls:
  - mem_en = 1, alu_op = ADD, am = ~[25], size = [22].
  - [20]=1 (load): load = 1, rf_en = 1, rw = 0.
  - [20]=0 (store): rw = 1, rf_en = 0.
- BR controls:
  - b = 1.
  - If [24]=1: bl = 1, rf_en = 1, rd = 14.
- ID/EX update, priority reset > flush > (stall | hazard_stall | ~instr_valid) > decode. Every case except decode loads a bubble.
- ID/EX also latches cond = [31:28].
- EX/MEM and MEM/WB always advance; stall does not freeze them.
- Condition evaluation: standard ARM table over flags_ex; 1110 → pass; 1111 → fail.
- When cond fails, ex_ctrl is all 0 and branch_taken = 0. The gated bundle is what enters EX/MEM.
- hazard_stall (combinational, same cycle): asserted when EX holds load & rf_en and ex_rd matches a source of the ID instruction:
  - Rn [19:16] for DP/LS;
  - Rm [3:0] for register-operand DP/LS;
  - Rd [15:12] for a store.
  - Gated by instr_valid. Not asserted for bubbles or BR.
- Simultaneous flush and hazard: flush wins; hazard_stall still reflects the comparison.
- Reset mid-pipeline clears all three stages in one cycle.

Optional Feature:
CU_COND_EXEC_EN
- Defined: condition evaluation as above.
- Undefined: cond_pass is tied 1, flags_ex is ignored, and the cond field is not stored.

Decomposition:
- Package cu_pkg holds:
  - CTRL bit-index localparams and CTRL_W;
  - class enum (DP/LS/BR/NONE);
  - ALU opcode constants;
  - ARM condition codes;
  - the NOP bundle constant.
- Sub-module cu_decode: purely combinational instr → {alu_op, ctrl, rd, cond, srcs}.
- Top level holds the stage registers, condition check and hazard logic.

Test Plan:
- ADD r1,r2,r3 (0xE0821003) → next cycle ex_alu_op=0000, rf_en=1, s_en=0, ex_rd=1; appears in wb_ctrl 2 cycles later.
- LDR r1,[r2] (0xE5921000), then ADD r3,r1,r4 (0xE0813004) → hazard_stall=1 for one cycle, EX bubble, ADD issues on the following cycle.
- CMP r1,#0 (0xE3510000) → alu_op=0010, s_en=1, rf_en=0, am=1.
- BNE (0x1A000004) with flags_ex=0100 → cond_pass=0, branch_taken=0, mem_ctrl=0 next cycle. With flags_ex=0000 → branch_taken=1.
- BL (0xEB000010) → bl=1, rf_en=1, ex_rd=14. Assert flush and stall together with a valid instruction → ID/EX bubble.
- Reset asserted with all stages full → next cycle ex/mem/wb_ctrl=0, ex_alu_op=1110.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared types and constants for the pipelined ARM-subset control unit.
// The CU_COND_EXEC_EN build option is consumed by pipelined_control_unit.
package cu_pkg;

  // Control bundle bit positions, MSB first: am s_en load rf_en size rw mem_en bl b
  localparam int CTRL_AM     = 8;
  localparam int CTRL_S_EN   = 7;
  localparam int CTRL_LOAD   = 6;
  localparam int CTRL_RF_EN  = 5;
  localparam int CTRL_SIZE   = 4;
  localparam int CTRL_RW     = 3;
  localparam int CTRL_MEM_EN = 2;
  localparam int CTRL_BL     = 1;
  localparam int CTRL_B      = 0;
  localparam int CTRL_W      = 9;

  localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

  typedef enum logic [1:0] {
    CLS_DP,
    CLS_LS,
    CLS_BR,
    CLS_NONE
  } instr_class_e;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_ADC = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_SBC = 4'b0011;
  localparam logic [3:0] ALU_RSB = 4'b0100;
  localparam logic [3:0] ALU_RSC = 4'b0101;
  localparam logic [3:0] ALU_AND = 4'b0110;
  localparam logic [3:0] ALU_ORR = 4'b0111;
  localparam logic [3:0] ALU_EOR = 4'b1000;
  localparam logic [3:0] ALU_MOV = 4'b1010;
  localparam logic [3:0] ALU_MVN = 4'b1011;
  localparam logic [3:0] ALU_BIC = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  function automatic logic [3:0] dp_alu_op(input logic [3:0] opc);
    case (opc)
      4'b0000: dp_alu_op = ALU_AND;
      4'b0001: dp_alu_op = ALU_EOR;
      4'b0010: dp_alu_op = ALU_SUB;
      4'b0011: dp_alu_op = ALU_RSB;
      4'b0100: dp_alu_op = ALU_ADD;
      4'b0101: dp_alu_op = ALU_ADC;
      4'b0110: dp_alu_op = ALU_SBC;
      4'b0111: dp_alu_op = ALU_RSC;
      4'b1000: dp_alu_op = ALU_AND;
      4'b1001: dp_alu_op = ALU_EOR;
      4'b1010: dp_alu_op = ALU_SUB;
      4'b1011: dp_alu_op = ALU_ADD;
      4'b1100: dp_alu_op = ALU_ORR;
      4'b1101: dp_alu_op = ALU_MOV;
      4'b1110: dp_alu_op = ALU_BIC;
      default: dp_alu_op = ALU_MVN;
    endcase
  endfunction

  // flags are NZCV in bits [3:0]
  function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      COND_EQ: cond_check = z;
      COND_NE: cond_check = !z;
      COND_CS: cond_check = c;
      COND_CC: cond_check = !c;
      COND_MI: cond_check = n;
      COND_PL: cond_check = !n;
      COND_VS: cond_check = v;
      COND_VC: cond_check = !v;
      COND_HI: cond_check = c && !z;
      COND_LS: cond_check = !c || z;
      COND_GE: cond_check = (n == v);
      COND_LT: cond_check = (n != v);
      COND_GT: cond_check = !z && (n == v);
      COND_LE: cond_check = z || (n != v);
      COND_AL: cond_check = 1'b1;
      default: cond_check = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pipelined_control_unit_decode.sv
// Combinational ID-stage decoder: instruction -> alu_op, control bundle,
// destination, condition and the source registers used for hazard checks.
module pipelined_control_unit_decode
  import cu_pkg::*;
#(
  parameter int                  ALU_OP_W   = 4,
  parameter int                  REG_IDX_W  = 4,
  parameter logic [ALU_OP_W-1:0] NOP_ALU_OP = 4'b1110
) (
  input  logic [31:0]           i_instr,
  output logic [ALU_OP_W-1:0]   o_alu_op,
  output logic [CTRL_W-1:0]     o_ctrl,
  output logic [REG_IDX_W-1:0]  o_rd,
  output logic [3:0]            o_cond,
  output logic [REG_IDX_W-1:0]  o_src_rn,
  output logic [REG_IDX_W-1:0]  o_src_rm,
  output logic [REG_IDX_W-1:0]  o_src_rd,
  output logic                  o_use_rn,
  output logic                  o_use_rm,
  output logic                  o_use_rd
);

  instr_class_e w_cls;
  logic         w_unused_bits;

  assign w_unused_bits = ^{i_instr[11:8], i_instr[6:5]};
  assign o_cond        = i_instr[31:28];
  assign o_src_rn      = REG_IDX_W'(i_instr[19:16]);
  assign o_src_rm      = REG_IDX_W'(i_instr[3:0]);
  assign o_src_rd      = REG_IDX_W'(i_instr[15:12]);

  // Multiplies/extra load-stores and media encodings fall out as bubbles
  always_comb begin
    w_cls = CLS_NONE;
    if (i_instr[27:26] == 2'b00 && !(!i_instr[25] && i_instr[7] && i_instr[4]))
      w_cls = CLS_DP;
    else if (i_instr[27:26] == 2'b01 && !(i_instr[25] && i_instr[4]))
      w_cls = CLS_LS;
    else if (i_instr[27:25] == 3'b101)
      w_cls = CLS_BR;
  end

  always_comb begin
    o_alu_op = NOP_ALU_OP;
    o_ctrl   = CTRL_NOP;
    o_rd     = '0;
    o_use_rn = 1'b0;
    o_use_rm = 1'b0;
    o_use_rd = 1'b0;
    case (w_cls)
      CLS_DP: begin
        o_alu_op           = ALU_OP_W'(dp_alu_op(i_instr[24:21]));
        o_ctrl[CTRL_AM]    = i_instr[25];
        o_ctrl[CTRL_S_EN]  = i_instr[20];
        o_ctrl[CTRL_RF_EN] = 1'b1;
        // TST/TEQ/CMP/CMN only set flags
        if (i_instr[24:23] == 2'b10) begin
          o_ctrl[CTRL_RF_EN] = 1'b0;
          o_ctrl[CTRL_S_EN]  = 1'b1;
        end
        o_rd     = REG_IDX_W'(i_instr[15:12]);
        o_use_rn = 1'b1;
        o_use_rm = !i_instr[25];
      end
      CLS_LS: begin
        o_alu_op            = ALU_OP_W'(ALU_ADD);
        o_ctrl[CTRL_MEM_EN] = 1'b1;
        o_ctrl[CTRL_AM]     = !i_instr[25];
        o_ctrl[CTRL_SIZE]   = i_instr[22];
        if (i_instr[20]) begin
          o_ctrl[CTRL_LOAD]  = 1'b1;
          o_ctrl[CTRL_RF_EN] = 1'b1;
        end else begin
          o_ctrl[CTRL_RW] = 1'b1;
        end
        o_rd     = REG_IDX_W'(i_instr[15:12]);
        o_use_rn = 1'b1;
        o_use_rm = i_instr[25];
        o_use_rd = !i_instr[20];
      end
      CLS_BR: begin
        o_alu_op       = ALU_OP_W'(ALU_ADD);
        o_ctrl[CTRL_B] = 1'b1;
        if (i_instr[24]) begin
          o_ctrl[CTRL_BL]    = 1'b1;
          o_ctrl[CTRL_RF_EN] = 1'b1;
          o_rd               = REG_IDX_W'(14);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pipelined_control_unit.sv
// ID/EX, EX/MEM, MEM/WB control pipeline with condition check and load-use detection.
// Define CU_COND_EXEC_EN to enable conditional execution on flags_ex.
module pipelined_control_unit
  import cu_pkg::*;
#(
  parameter int                  ALU_OP_W   = 4,
  parameter int                  NUM_REGS   = 16,
  parameter logic [ALU_OP_W-1:0] NOP_ALU_OP = 4'b1110,
  localparam int                 REG_IDX_W  = $clog2(NUM_REGS)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [31:0]           i_instr_id,
  input  logic                  i_instr_valid,
  input  logic                  i_stall,
  input  logic                  i_flush,
  input  logic [3:0]            i_flags_ex,
  output logic [ALU_OP_W-1:0]   o_ex_alu_op,
  output logic [CTRL_W-1:0]     o_ex_ctrl,
  output logic [REG_IDX_W-1:0]  o_ex_rd,
  output logic [CTRL_W-1:0]     o_mem_ctrl,
  output logic [CTRL_W-1:0]     o_wb_ctrl,
  output logic [REG_IDX_W-1:0]  o_wb_rd,
  output logic                  o_cond_pass,
  output logic                  o_branch_taken,
  output logic                  o_hazard_stall
);

  logic [ALU_OP_W-1:0]  w_dec_alu_op;
  logic [CTRL_W-1:0]    w_dec_ctrl;
  logic [REG_IDX_W-1:0] w_dec_rd, w_src_rn, w_src_rm, w_src_rd;
  logic [3:0]           w_dec_cond;
  logic                 w_use_rn, w_use_rm, w_use_rd;
  logic                 w_ex_load, w_hazard, w_bubble;

  logic [ALU_OP_W-1:0]  r_idex_alu_op;
  logic [CTRL_W-1:0]    r_idex_ctrl;
  logic [REG_IDX_W-1:0] r_idex_rd;
  logic [CTRL_W-1:0]    r_exmem_ctrl, r_memwb_ctrl;
  logic [REG_IDX_W-1:0] r_exmem_rd, r_memwb_rd;

  pipelined_control_unit_decode #(
    .ALU_OP_W  (ALU_OP_W),
    .REG_IDX_W (REG_IDX_W),
    .NOP_ALU_OP(NOP_ALU_OP)
  ) u_decode (
    .i_instr (i_instr_id),
    .o_alu_op(w_dec_alu_op),
    .o_ctrl  (w_dec_ctrl),
    .o_rd    (w_dec_rd),
    .o_cond  (w_dec_cond),
    .o_src_rn(w_src_rn),
    .o_src_rm(w_src_rm),
    .o_src_rd(w_src_rd),
    .o_use_rn(w_use_rn),
    .o_use_rm(w_use_rm),
    .o_use_rd(w_use_rd)
  );

  // Uses the ungated EX bundle so the stall does not depend on this cycle's flags
  assign w_ex_load = r_idex_ctrl[CTRL_LOAD] && r_idex_ctrl[CTRL_RF_EN];
  assign w_hazard  = i_instr_valid && w_ex_load &&
                     ((w_use_rn && w_src_rn == r_idex_rd) ||
                      (w_use_rm && w_src_rm == r_idex_rd) ||
                      (w_use_rd && w_src_rd == r_idex_rd));
  assign w_bubble  = i_reset || i_flush || i_stall || w_hazard || !i_instr_valid;

  always_ff @(posedge i_clk) begin
    if (w_bubble) begin
      r_idex_alu_op <= NOP_ALU_OP;
      r_idex_ctrl   <= CTRL_NOP;
      r_idex_rd     <= '0;
    end else begin
      r_idex_alu_op <= w_dec_alu_op;
      r_idex_ctrl   <= w_dec_ctrl;
      r_idex_rd     <= w_dec_rd;
    end
  end

`ifdef CU_COND_EXEC_EN
  logic [3:0] r_idex_cond;

  // Bubbles carry NV so an empty EX stage never reports a passing condition
  always_ff @(posedge i_clk) begin
    if (w_bubble) r_idex_cond <= COND_NV;
    else          r_idex_cond <= w_dec_cond;
  end

  assign o_cond_pass = cond_check(r_idex_cond, i_flags_ex);
`else
  logic w_unused_cond;
  assign w_unused_cond = ^{w_dec_cond, i_flags_ex};
  assign o_cond_pass   = 1'b1;
`endif

  assign o_ex_ctrl      = o_cond_pass ? r_idex_ctrl : CTRL_NOP;
  assign o_ex_alu_op    = r_idex_alu_op;
  assign o_ex_rd        = r_idex_rd;
  assign o_branch_taken = o_ex_ctrl[CTRL_B];
  assign o_hazard_stall = w_hazard;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_exmem_ctrl <= CTRL_NOP;
      r_exmem_rd   <= '0;
      r_memwb_ctrl <= CTRL_NOP;
      r_memwb_rd   <= '0;
    end else begin
      r_exmem_ctrl <= o_ex_ctrl;
      r_exmem_rd   <= r_idex_rd;
      r_memwb_ctrl <= r_exmem_ctrl;
      r_memwb_rd   <= r_exmem_rd;
    end
  end

  assign o_mem_ctrl = r_exmem_ctrl;
  assign o_wb_ctrl  = r_memwb_ctrl;
  assign o_wb_rd    = r_memwb_rd;

endmodule
